// File: rtl/time_set_controller_pkg.sv
// Shared types and constants for the century-clock time/date setting logic.
package time_set_controller_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_E_YEAR  = 3'd1,
    ST_E_MONTH = 3'd2,
    ST_E_DAY   = 3'd3,
    ST_E_HOUR  = 3'd4,
    ST_E_MIN   = 3'd5,
    ST_COMMIT  = 3'd6
  } state_t;

  localparam logic [2:0] FIELD_NONE  = 3'd0;
  localparam logic [2:0] FIELD_YEAR  = 3'd1;
  localparam logic [2:0] FIELD_MONTH = 3'd2;
  localparam logic [2:0] FIELD_DAY   = 3'd3;
  localparam logic [2:0] FIELD_HOUR  = 3'd4;
  localparam logic [2:0] FIELD_MIN   = 3'd5;

  localparam logic [5:0] MIN_MAX   = 6'd59;
  localparam logic [4:0] HOUR_MAX  = 5'd23;
  localparam logic [3:0] MONTH_MAX = 4'd12;

  // Gregorian rule: century years are leap only when divisible by 400.
  function automatic logic is_leap(input logic [15:0] year);
    return (year % 16'd4 == 16'd0) &&
           ((year % 16'd100 != 16'd0) || (year % 16'd400 == 16'd0));
  endfunction

endpackage

// File: rtl/time_set_controller_if.sv
// Load handshake bus from the setting controller to the counter datapath.
interface time_set_controller_if;
  logic        load_valid;
  logic        load_ready;
  logic [5:0]  load_sec;
  logic [5:0]  load_min;
  logic [4:0]  load_hour;
  logic [4:0]  load_day;
  logic [3:0]  load_month;
  logic [15:0] load_year;

  modport master (
    output load_valid, load_sec, load_min, load_hour, load_day, load_month, load_year,
    input  load_ready
  );

  modport slave (
    input  load_valid, load_sec, load_min, load_hour, load_day, load_month, load_year,
    output load_ready
  );
endinterface

// File: rtl/time_set_controller_days_in_month.sv
// Combinational days-in-month lookup; invalid months report 31.
module days_in_month
  import time_set_controller_pkg::*;
(
  input  logic [3:0]  month,
  input  logic [15:0] year,
  output logic [4:0]  dim
);
  always_comb begin
    dim = 5'd31;
    case (month)
      4'd2:                      dim = is_leap(year) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   dim = 5'd30;
      default:                   dim = 5'd31;
    endcase
  end
endmodule

// File: rtl/time_set_controller.sv
// Button-driven time/date editor: snapshots live time, steps fields, commits via load handshake.
module time_set_controller
  import time_set_controller_pkg::*;
#(
  parameter int YEAR_MIN       = 2000,
  parameter int YEAR_MAX       = 2099,
  parameter int TIMEOUT_CYCLES = 30000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        btn_cancel,
  input  logic [5:0]  cur_min,
  input  logic [4:0]  cur_hour,
  input  logic [4:0]  cur_day,
  input  logic [3:0]  cur_month,
  input  logic [15:0] cur_year,
  output logic        run_en,
  output logic [2:0]  edit_field,
  time_set_controller_if.master load_if
);
  localparam logic [15:0] YMIN = 16'(YEAR_MIN);
  localparam logic [15:0] YMAX = 16'(YEAR_MAX);
  localparam int          TW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state_reg, state_next;
  logic [TW-1:0] timeout_cnt_reg;
  logic [15:0]   year_reg;
  logic [3:0]    month_reg;
  logic [4:0]    day_reg, hour_reg;
  logic [5:0]    min_reg;

  logic        in_edit, any_btn, timeout_hit, step_up, step;
  logic [15:0] year_step, cand_year;
  logic [3:0]  month_step, cand_month;
  logic [4:0]  day_step, hour_step, dim_cand, day_clamped;
  logic [5:0]  min_step;

  assign in_edit     = (state_reg != ST_RUN) && (state_reg != ST_COMMIT);
  assign any_btn     = btn_mode | btn_inc | btn_dec | btn_cancel;
  assign timeout_hit = in_edit && !any_btn && (timeout_cnt_reg == TO_LAST);
  assign step_up     = btn_inc & ~btn_dec;
  assign step        = in_edit & (btn_inc ^ btn_dec) & ~btn_cancel & ~btn_mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_RUN;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    run_en     = 1'b0;
    edit_field = FIELD_NONE;
    case (state_reg)
      ST_RUN: begin
        run_en = 1'b1;
        if (btn_mode) state_next = ST_E_YEAR;
      end
      ST_E_YEAR:  edit_field = FIELD_YEAR;
      ST_E_MONTH: edit_field = FIELD_MONTH;
      ST_E_DAY:   edit_field = FIELD_DAY;
      ST_E_HOUR:  edit_field = FIELD_HOUR;
      ST_E_MIN:   edit_field = FIELD_MIN;
      ST_COMMIT:  if (load_if.load_ready) state_next = ST_RUN;
      default:    state_next = ST_RUN;
    endcase
    // Edit states advance in encoding order; cancel and timeout win over mode.
    if (in_edit) begin
      if (btn_cancel || timeout_hit) state_next = ST_RUN;
      else if (btn_mode)             state_next = state_t'(state_reg + 3'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            timeout_cnt_reg <= '0;
    else if (!in_edit || any_btn || state_next != state_reg) timeout_cnt_reg <= '0;
    else                                                timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
  end

  // Candidate values for each field; out-of-range snapshots restart at the field minimum.
  always_comb begin
    if (year_reg < YMIN || year_reg > YMAX) year_step = YMIN;
    else if (step_up) year_step = (year_reg == YMAX) ? YMIN : year_reg + 16'd1;
    else              year_step = (year_reg == YMIN) ? YMAX : year_reg - 16'd1;

    if (month_reg == 4'd0 || month_reg > MONTH_MAX) month_step = 4'd1;
    else if (step_up) month_step = (month_reg == MONTH_MAX) ? 4'd1 : month_reg + 4'd1;
    else              month_step = (month_reg == 4'd1) ? MONTH_MAX : month_reg - 4'd1;

    cand_year  = (state_reg == ST_E_YEAR  && step) ? year_step  : year_reg;
    cand_month = (state_reg == ST_E_MONTH && step) ? month_step : month_reg;
  end

  days_in_month u_dim (
    .month (cand_month),
    .year  (cand_year),
    .dim   (dim_cand)
  );

  always_comb begin
    day_clamped = (day_reg > dim_cand) ? dim_cand : day_reg;

    if (day_reg == 5'd0 || day_reg > dim_cand) day_step = 5'd1;
    else if (step_up) day_step = (day_reg == dim_cand) ? 5'd1 : day_reg + 5'd1;
    else              day_step = (day_reg == 5'd1) ? dim_cand : day_reg - 5'd1;

    if (hour_reg > HOUR_MAX) hour_step = 5'd0;
    else if (step_up) hour_step = (hour_reg == HOUR_MAX) ? 5'd0 : hour_reg + 5'd1;
    else              hour_step = (hour_reg == 5'd0) ? HOUR_MAX : hour_reg - 5'd1;

    if (min_reg > MIN_MAX) min_step = 6'd0;
    else if (step_up) min_step = (min_reg == MIN_MAX) ? 6'd0 : min_reg + 6'd1;
    else              min_step = (min_reg == 6'd0) ? MIN_MAX : min_reg - 6'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      year_reg  <= '0;
      month_reg <= '0;
      day_reg   <= '0;
      hour_reg  <= '0;
      min_reg   <= '0;
    end else if (state_reg == ST_RUN && btn_mode) begin
      year_reg  <= cur_year;
      month_reg <= cur_month;
      day_reg   <= cur_day;
      hour_reg  <= cur_hour;
      min_reg   <= cur_min;
    end else if (step) begin
      case (state_reg)
        ST_E_YEAR:  begin year_reg  <= year_step;  day_reg <= day_clamped; end
        ST_E_MONTH: begin month_reg <= month_step; day_reg <= day_clamped; end
        ST_E_DAY:   day_reg  <= day_step;
        ST_E_HOUR:  hour_reg <= hour_step;
        ST_E_MIN:   min_reg  <= min_step;
        default: ;
      endcase
    end
  end

  assign load_if.load_valid = (state_reg == ST_COMMIT);
  assign load_if.load_sec   = 6'd0;
  assign load_if.load_min   = min_reg;
  assign load_if.load_hour  = hour_reg;
  assign load_if.load_day   = day_reg;
  assign load_if.load_month = month_reg;
  assign load_if.load_year  = year_reg;
endmodule

// File: tb/tb_time_set_controller.sv
// Self-checking bench: field-step vector table, commit scoreboard, reset/priority/timeout sequences.
module tb_time_set_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic        btn_mode, btn_inc, btn_dec, btn_cancel;
  logic [5:0]  cur_min;
  logic [4:0]  cur_hour, cur_day;
  logic [3:0]  cur_month;
  logic [15:0] cur_year;
  logic        run_en;
  logic [2:0]  edit_field;

  time_set_controller_if lif();

  time_set_controller #(
    .YEAR_MIN       (2000),
    .YEAR_MAX       (2099),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .btn_dec    (btn_dec),
    .btn_cancel (btn_cancel),
    .cur_min    (cur_min),
    .cur_hour   (cur_hour),
    .cur_day    (cur_day),
    .cur_month  (cur_month),
    .cur_year   (cur_year),
    .run_en     (run_en),
    .edit_field (edit_field),
    .load_if    (lif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] y;
    logic [3:0]  mo;
    logic [4:0]  d;
    logic [4:0]  h;
    logic [5:0]  mi;
  } tv_t;

  typedef struct {
    string name;
    tv_t   start;
    int    field;
    logic  inc;
    logic  dec;
    tv_t   expect_tv;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_handshakes = 0;
  tv_t  exp_q[$];
  vec_t vecs[$];

  function automatic tv_t shadow();
    return {lif.load_year, lif.load_month, lif.load_day, lif.load_hour, lif.load_min};
  endfunction

  function automatic tv_t mk_tv(int y, int mo, int d, int h, int mi);
    return {16'(y), 4'(mo), 5'(d), 5'(h), 6'(mi)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic m, input logic i, input logic d, input logic c);
    btn_mode = m; btn_inc = i; btn_dec = d; btn_cancel = c;
    tick();
    btn_mode = 0; btn_inc = 0; btn_dec = 0; btn_cancel = 0;
  endtask

  task automatic enter_edit(input tv_t t);
    {cur_year, cur_month, cur_day, cur_hour, cur_min} = t;
    pulse(1, 0, 0, 0);
  endtask

  // Scoreboard: every valid&&ready cycle must match the oldest queued commit.
  always @(negedge clk) begin
    tv_t e;
    if (!rst && lif.load_valid && lif.load_ready) begin
      n_handshakes++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_load: got %0h required no load", shadow());
      end else begin
        e = exp_q.pop_front();
        check("load_values", 64'(shadow()), 64'(e));
        check("load_sec", 64'(lif.load_sec), 64'd0);
      end
    end
  end

  initial begin
    rst = 1; btn_mode = 0; btn_inc = 0; btn_dec = 0; btn_cancel = 0;
    cur_year = 0; cur_month = 0; cur_day = 0; cur_hour = 0; cur_min = 0;
    lif.load_ready = 0;

    vecs.push_back('{"month_inc_clamp_leap", mk_tv(2024,1,31,12,30), 2, 1, 0, mk_tv(2024,2,29,12,30)});
    vecs.push_back('{"year_inc_clamp",       mk_tv(2024,2,29,8,0),   1, 1, 0, mk_tv(2025,2,28,8,0)});
    vecs.push_back('{"y2100_nonleap",        mk_tv(2100,1,31,0,0),   2, 1, 0, mk_tv(2100,2,28,0,0)});
    vecs.push_back('{"min_wrap",             mk_tv(2023,5,5,10,59),  5, 1, 0, mk_tv(2023,5,5,10,0)});
    vecs.push_back('{"hour_wrap",            mk_tv(2023,5,5,0,7),    4, 0, 1, mk_tv(2023,5,5,23,7)});
    vecs.push_back('{"year_wrap",            mk_tv(2099,3,15,1,1),   1, 1, 0, mk_tv(2000,3,15,1,1)});
    vecs.push_back('{"day_wrap_apr",         mk_tv(2023,4,1,1,1),    3, 0, 1, mk_tv(2023,4,30,1,1)});
    vecs.push_back('{"inc_dec_same",         mk_tv(2023,4,10,10,10), 4, 1, 1, mk_tv(2023,4,10,10,10)});
    vecs.push_back('{"year_below_min",       mk_tv(1999,6,10,2,3),   1, 0, 1, mk_tv(2000,6,10,2,3)});
    vecs.push_back('{"month_12_inc",         mk_tv(2023,12,31,4,4),  2, 1, 0, mk_tv(2023,1,31,4,4)});
    vecs.push_back('{"month_1_dec",          mk_tv(2023,1,15,4,4),   2, 0, 1, mk_tv(2023,12,15,4,4)});
    vecs.push_back('{"day_leap_2000",        mk_tv(2000,2,28,5,5),   3, 1, 0, mk_tv(2000,2,29,5,5)});
    vecs.push_back('{"month_dec_clamp",      mk_tv(2024,3,31,6,6),   2, 0, 1, mk_tv(2024,2,29,6,6)});
    vecs.push_back('{"day_31_inc",           mk_tv(2023,1,31,7,7),   3, 1, 0, mk_tv(2023,1,1,7,7)});
    vecs.push_back('{"year_min_dec",         mk_tv(2000,5,5,8,8),    1, 0, 1, mk_tv(2099,5,5,8,8)});
    vecs.push_back('{"year_dec_clamp",       mk_tv(2024,2,29,9,9),   1, 0, 1, mk_tv(2023,2,28,9,9)});

    // Reset state
    tick(); tick();
    check("rst_run_en", 64'(run_en), 64'd1);
    check("rst_edit_field", 64'(edit_field), 64'd0);
    check("rst_load_valid", 64'(lif.load_valid), 64'd0);
    check("rst_shadow", 64'(shadow()), 64'd0);
    rst = 0;
    tick();

    // Asynchronous reset in the middle of E_DAY
    enter_edit(mk_tv(2023,7,14,9,45));
    pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 0);
    check("pre_reset_field", 64'(edit_field), 64'd3);
    #2 rst = 1;
    #1;
    check("async_rst_run_en", 64'(run_en), 64'd1);
    check("async_rst_field", 64'(edit_field), 64'd0);
    check("async_rst_valid", 64'(lif.load_valid), 64'd0);
    tick();
    rst = 0;
    tick();

    // Field stepping vectors
    for (int i = 0; i < vecs.size(); i++) begin
      enter_edit(vecs[i].start);
      for (int k = 1; k < vecs[i].field; k++) pulse(1, 0, 0, 0);
      check({vecs[i].name, "_field"}, 64'(edit_field), 64'(vecs[i].field));
      pulse(0, vecs[i].inc, vecs[i].dec, 0);
      check(vecs[i].name, 64'(shadow()), 64'(vecs[i].expect_tv));
      pulse(0, 0, 0, 1);
      check({vecs[i].name, "_cancel"}, 64'({run_en, lif.load_valid}), 64'b10);
    end

    // inc while running is ignored
    pulse(0, 1, 0, 0);
    check("run_inc_ignored", 64'(shadow()), 64'(vecs[vecs.size()-1].expect_tv));

    // Full commit with ready held low first; cancel ignored in COMMIT
    enter_edit(mk_tv(2023,1,31,23,59));
    check("edit_run_en_low", 64'(run_en), 64'd0);
    repeat (5) pulse(1, 0, 0, 0);
    exp_q.push_back(mk_tv(2023,1,31,23,59));
    check("commit_valid", 64'({lif.load_valid, run_en, edit_field}), 64'b1_0_000);
    repeat (4) tick();
    pulse(0, 0, 0, 1);
    check("commit_hold_valid", 64'(lif.load_valid), 64'd1);
    check("commit_hold_values", 64'(shadow()), 64'(mk_tv(2023,1,31,23,59)));
    lif.load_ready = 1;
    tick();
    lif.load_ready = 0;
    check("commit_done", 64'({lif.load_valid, run_en}), 64'b01);
    check("handshake_count", 64'(n_handshakes), 64'd1);

    // mode+inc advances without stepping; cancel+mode aborts
    enter_edit(mk_tv(2023,8,8,8,8));
    pulse(1, 1, 0, 0);
    check("mode_inc_field", 64'(edit_field), 64'd2);
    check("mode_inc_value", 64'(shadow()), 64'(mk_tv(2023,8,8,8,8)));
    pulse(1, 0, 0, 1);
    check("cancel_mode", 64'({run_en, edit_field, lif.load_valid}), 64'b1_000_0);

    // Idle timeout in E_HOUR
    enter_edit(mk_tv(2022,3,3,3,3));
    repeat (3) pulse(1, 0, 0, 0);
    repeat (15) tick();
    check("timeout_pending", 64'(edit_field), 64'd4);
    tick();
    check("timeout_abort", 64'({run_en, edit_field, lif.load_valid}), 64'b1_000_0);

    // Second commit, loaded immediately
    enter_edit(mk_tv(2050,6,15,12,0));
    repeat (5) pulse(1, 0, 0, 0);
    exp_q.push_back(mk_tv(2050,6,15,12,0));
    lif.load_ready = 1;
    tick();
    lif.load_ready = 0;
    tick();
    check("handshake_count2", 64'(n_handshakes), 64'd2);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
